// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core-side and memory-side bus bundle for mem_arbiter
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ready;
   logic [DW-1:0] i_rdata;
   logic          i_stall;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ready;
   logic [DW-1:0] d_rdata;
   logic          d_stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one shared single-port memory
// Data wins ties; the just-served port is masked on completion so both ports alternate.
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus,
   output logic [CW-1:0] wait_i,
   output logic [CW-1:0] wait_d
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_I = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;

   logic [1:0]    r_state;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [CW-1:0] r_wait_i;
   logic [CW-1:0] r_wait_d;

   logic w_done;
   logic w_i_ready;
   logic w_d_ready;
   logic w_free;
   logic w_grant_d;
   logic w_grant_i;
   logic w_i_stall;
   logic w_d_stall;

   assign w_done    = (r_state != S_IDLE) && bus.mem_ready;
   assign w_i_ready = w_done && (r_state == S_BUSY_I);
   assign w_d_ready = w_done && (r_state == S_BUSY_D);
   assign w_free    = (r_state == S_IDLE) || w_done;

   // A completing port still holds req this cycle, so it is excluded from re-arbitration.
   assign w_grant_d = w_free && bus.d_req && (r_state != S_BUSY_D);
   assign w_grant_i = w_free && bus.i_req && !w_grant_d && (r_state != S_BUSY_I);

   assign w_i_stall = bus.i_req && !w_i_ready;
   assign w_d_stall = bus.d_req && !w_d_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_grant_d) begin
         r_state     <= S_BUSY_D;
         r_mem_req   <= 1'b1;
         r_mem_we    <= bus.d_we;
         r_mem_addr  <= bus.d_addr;
         r_mem_wdata <= bus.d_wdata;
      end else if (w_grant_i) begin
         r_state     <= S_BUSY_I;
         r_mem_req   <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= bus.i_addr;
      end else if (w_done) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_i <= '0;
         r_wait_d <= '0;
      end else begin
         if (w_i_stall && (r_wait_i != {CW{1'b1}})) begin
            r_wait_i <= r_wait_i + CW'(1);
         end
         if (w_d_stall && (r_wait_d != {CW{1'b1}})) begin
            r_wait_d <= r_wait_d + CW'(1);
         end
      end
   end

   assign bus.i_ready   = w_i_ready;
   assign bus.d_ready   = w_d_ready;
   assign bus.i_rdata   = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;
   assign bus.i_stall   = w_i_stall;
   assign bus.d_stall   = w_d_stall;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign wait_i        = r_wait_i;
   assign wait_d        = r_wait_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;
   logic        clk;
   logic        rst;
   logic [31:0] wi1, wd1;
   logic [3:0]  wi2, wd2;
   int          tests;
   int          fails;

   mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
   mem_arbiter_if #(.AW(32), .DW(32)) b2 ();

   mem_arbiter #(.AW(32), .DW(32), .CW(32)) u_dut (
      .clk(clk), .reset(rst), .bus(b1), .wait_i(wi1), .wait_d(wd1)
   );

   mem_arbiter #(.AW(32), .DW(32), .CW(4)) u_sat (
      .clk(clk), .reset(rst), .bus(b2), .wait_i(wi2), .wait_d(wd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ireq;
      logic [31:0] iaddr;
      logic        dreq, dwe;
      logic [31:0] daddr, dwdata;
      logic        mrdy;
      logic [31:0] mrdata;
      logic        emreq, ca, emwe;
      logic [31:0] emaddr;
      logic        cw;
      logic [31:0] emwdata;
      logic        eirdy, edrdy, erd;
      logic [31:0] ewi, ewd;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(
      input logic rst_v, ireq, input logic [31:0] iaddr,
      input logic dreq, dwe, input logic [31:0] daddr, dwdata,
      input logic mrdy, input logic [31:0] mrdata,
      input logic emreq, ca, emwe, input logic [31:0] emaddr,
      input logic cw, input logic [31:0] emwdata,
      input logic eirdy, edrdy, erd, input logic [31:0] ewi, ewd);
      vec_t v;
      v.rst = rst_v; v.ireq = ireq; v.iaddr = iaddr;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
      v.mrdy = mrdy; v.mrdata = mrdata;
      v.emreq = emreq; v.ca = ca; v.emwe = emwe; v.emaddr = emaddr;
      v.cw = cw; v.emwdata = emwdata;
      v.eirdy = eirdy; v.edrdy = edrdy; v.erd = erd; v.ewi = ewi; v.ewd = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst          = v.rst;
      b1.i_req     = v.ireq;
      b1.i_addr    = v.iaddr;
      b1.d_req     = v.dreq;
      b1.d_we      = v.dwe;
      b1.d_addr    = v.daddr;
      b1.d_wdata   = v.dwdata;
      b1.mem_ready = v.mrdy;
      b1.mem_rdata = v.mrdata;
   endtask

   task automatic add_reset();
      tv.push_back(mk(1, 0,0, 0,0,0,0, 0,0, 0,1,0,0, 1,0, 0,0,0, 0,0));
   endtask

   initial begin
      vec_t v;
      logic d;
      tests = 0;
      fails = 0;
      rst = 1'b1;
      b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0;
      b1.d_wdata = 0; b1.mem_ready = 0; b1.mem_rdata = 0;
      b2.i_req = 0; b2.i_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0;
      b2.d_wdata = 0; b2.mem_ready = 0; b2.mem_rdata = 0;

      // single fetch, zero-wait memory; mem_ready in IDLE must be ignored
      add_reset();
      tv.push_back(mk(0,1,32'h10,0,0,0,0,1,32'h13, 0,0,0,0,0,0, 0,0,0, 0,0));
      tv.push_back(mk(0,1,32'h10,0,0,0,0,1,32'h13, 1,1,0,32'h10,0,0, 1,0,1, 1,0));
      tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 1,0));
      // simultaneous requests: D first, then I with no bubble
      add_reset();
      tv.push_back(mk(0,1,32'h20,1,0,32'h80,0,1,32'hAAAA0001, 0,0,0,0,0,0, 0,0,0, 0,0));
      tv.push_back(mk(0,1,32'h20,1,0,32'h80,0,1,32'h11111111, 1,1,0,32'h80,0,0, 0,1,1, 1,1));
      tv.push_back(mk(0,1,32'h20,0,0,0,0,1,32'h22222222, 1,1,0,32'h20,0,0, 1,0,1, 2,1));
      tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 2,1));
      // wait-state store; a fetch arriving mid-transaction must wait
      add_reset();
      tv.push_back(mk(0,0,0,1,1,32'h40,32'hDEADBEEF,0,0, 0,0,0,0,0,0, 0,0,0, 0,0));
      tv.push_back(mk(0,0,0,1,1,32'h40,32'hDEADBEEF,0,0, 1,1,1,32'h40,1,32'hDEADBEEF, 0,0,0, 0,1));
      tv.push_back(mk(0,1,32'h99,1,1,32'h40,32'hDEADBEEF,0,0, 1,1,1,32'h40,1,32'hDEADBEEF, 0,0,0, 0,2));
      tv.push_back(mk(0,1,32'h99,1,1,32'h40,32'hDEADBEEF,0,0, 1,1,1,32'h40,1,32'hDEADBEEF, 0,0,0, 1,3));
      tv.push_back(mk(0,1,32'h99,1,1,32'h40,32'hDEADBEEF,1,32'h0BADF00D, 1,1,1,32'h40,1,32'hDEADBEEF, 0,1,0, 2,4));
      tv.push_back(mk(0,1,32'h99,0,0,0,0,1,32'h5, 1,1,0,32'h99,0,0, 1,0,1, 3,4));
      tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 3,4));
      // fairness: both ports continuously pending for 8 transactions
      add_reset();
      tv.push_back(mk(0,1,32'h100,1,0,32'h200,0,1,0, 0,0,0,0,0,0, 0,0,0, 0,0));
      for (int k = 0; k < 8; k++) begin
         d = ((k % 2) == 0);
         tv.push_back(mk(0,1,32'h100,1,0,32'h200,0,1,32'hC0DE0000 + 32'(k),
                         1,1,0, d ? 32'h200 : 32'h100, 0,0, !d, d, 1,
                         32'((k + 1) / 2 + 1), 32'(k / 2 + 1)));
      end
      // the D request granted on the last hand-off completes even though req dropped
      tv.push_back(mk(0,0,0,0,0,0,0,1,32'h77, 1,1,0,32'h200,0,0, 0,1,1, 5,5));
      tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 5,5));

      for (int i = 0; i < tv.size(); i++) begin
         v = tv[i];
         @(posedge clk); #1;
         drive(v);
         @(negedge clk);
         chk($sformatf("v%0d mem_req", i), {31'b0, b1.mem_req}, {31'b0, v.emreq});
         chk($sformatf("v%0d i_ready", i), {31'b0, b1.i_ready}, {31'b0, v.eirdy});
         chk($sformatf("v%0d d_ready", i), {31'b0, b1.d_ready}, {31'b0, v.edrdy});
         chk($sformatf("v%0d i_stall", i), {31'b0, b1.i_stall}, {31'b0, v.ireq & ~v.eirdy});
         chk($sformatf("v%0d d_stall", i), {31'b0, b1.d_stall}, {31'b0, v.dreq & ~v.edrdy});
         chk($sformatf("v%0d wait_i", i), wi1, v.ewi);
         chk($sformatf("v%0d wait_d", i), wd1, v.ewd);
         if (v.ca) begin
            chk($sformatf("v%0d mem_addr", i), b1.mem_addr, v.emaddr);
            chk($sformatf("v%0d mem_we", i), {31'b0, b1.mem_we}, {31'b0, v.emwe});
         end
         if (v.cw) chk($sformatf("v%0d mem_wdata", i), b1.mem_wdata, v.emwdata);
         if (v.erd) chk($sformatf("v%0d rdata", i), v.eirdy ? b1.i_rdata : b1.d_rdata, v.mrdata);
      end

      // reset in the middle of a BUSY_D wait acts without a clock edge
      @(posedge clk); #1;
      b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h300; b1.mem_ready = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre-reset mem_req", {31'b0, b1.mem_req}, 32'd1);
      chk("pre-reset wait_d", wd1, 32'd7);
      #2 rst = 1'b1;
      #1;
      chk("async reset mem_req", {31'b0, b1.mem_req}, 32'd0);
      chk("async reset wait_i", wi1, 32'd0);
      chk("async reset wait_d", wd1, 32'd0);
      chk("async reset d_ready", {31'b0, b1.d_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      b1.d_req = 0; b1.i_req = 1; b1.i_addr = 32'h44; b1.mem_ready = 1; b1.mem_rdata = 32'h1234;
      @(negedge clk);
      chk("post-reset idle mem_req", {31'b0, b1.mem_req}, 32'd0);
      @(negedge clk);
      chk("post-reset mem_req", {31'b0, b1.mem_req}, 32'd1);
      chk("post-reset mem_addr", b1.mem_addr, 32'h44);
      chk("post-reset i_ready", {31'b0, b1.i_ready}, 32'd1);
      chk("post-reset i_rdata", b1.i_rdata, 32'h1234);
      @(posedge clk); #1;
      b1.i_req = 0; b1.mem_ready = 0;

      // saturation of a 4-bit counter under a stalled fetch
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      b2.i_req = 1; b2.i_addr = 32'h4; b2.mem_ready = 0;
      for (int n = 0; n <= 20; n++) begin
         @(negedge clk);
         if (n == 10) chk("sat wait_i at 10", {28'b0, wi2}, 32'd10);
         if (n == 15) chk("sat wait_i at 15", {28'b0, wi2}, 32'd15);
         if (n == 20) chk("sat wait_i at 20", {28'b0, wi2}, 32'd15);
      end
      chk("sat mem_req held", {31'b0, b2.mem_req}, 32'd1);
      chk("sat i_ready low", {31'b0, b2.i_ready}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port unified memory between the pipeline's instruction-fetch port (read-only) and data port (load/store).
- Sits between the 5-stage core's imem/dmem interfaces and a variable-latency memory.
- Provides the data port's priority rule, request/ready handshakes, per-port stall outputs and wait-cycle performance counters.

Parameters:
AW, 32, address width
DW, 32, data width
CW, 32, counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
i_req  in  1  instruction read request, held until i_ready
i_addr  in  AW  instruction address
i_ready  out  1  one-cycle completion pulse for the instruction port
i_rdata  out  DW  instruction data, valid only while i_ready=1
i_stall  out  1  i_req & ~i_ready
d_req  in  1  data request, held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ready  out  1  one-cycle completion pulse for the data port
d_rdata  out  DW  load data, valid only while d_ready=1
d_stall  out  1  d_req & ~d_ready
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_rdata  in  DW  memory read data
mem_ready  in  1  memory completes the current request this cycle
wait_i  out  CW  saturating count of cycles with i_stall=1
wait_d  out  CW  saturating count of cycles with d_stall=1

Behaviour:
- Clock is clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE; mem_req, mem_we=0; mem_addr, mem_wdata=0; wait_i, wait_d=0; i_ready, d_ready=0.
- The FSM has three states: IDLE, BUSY_I and BUSY_D.
- IDLE:
  - If d_req=1, latch d_we, d_addr and d_wdata into the mem_* registers, set mem_req=1, and go to BUSY_D.
  - Else if i_req=1, latch i_addr with mem_we=0, set mem_req=1, and go to BUSY_I.
  - Else stay in IDLE.
  - Data has priority on a simultaneous request.
- BUSY_x with mem_ready=0:
  - Hold all mem_* outputs stable.
  - Ignore new requests.
- BUSY_x with mem_ready=1 (completion cycle):
  - Assert x_ready for exactly this cycle.
  - x_rdata = mem_rdata, passed through combinationally.
  - In this same cycle, re-arbitrate with the just-served port masked, because its req is still high this cycle.
  - If the other port requests, latch its request, keep mem_req=1, and go to its BUSY state (zero-bubble hand-off).
  - Otherwise set mem_req=0 and go to IDLE.
- Consequence of the mask: when both ports are continuously pending, service alternates D, I, D, I. Neither port starves.
- Minimum latency:
  - Request seen in IDLE at cycle N → mem_req=1 at N+1.
  - If mem_ready=1 at N+1, ready pulses at N+1.
  - This gives 1 cycle request-to-ready with a zero-wait memory.
- i_rdata and d_rdata are don't-care when their ready signal is 0. The bench must not check them then.
- A requester that drops req while its request is in BUSY: the transaction still completes and ready still pulses. Requesters must not do this; it is not an error condition.
- Store completion: d_ready pulses and d_rdata is don't-care.
- mem_ready while in IDLE is ignored, with no ready pulse.
- Counters:
  - Increment by 1 each cycle the corresponding stall=1.
  - Saturate at 2^CW-1 with no wrap.
  - Reset clears them.
- Reset mid-transaction: return to IDLE at once, drop mem_req asynchronously, and clear the counters. The memory is reset by the same signal.

Test Plan:
- Single fetch, zero-wait memory:
  - Stimulus: i_req=1, i_addr=0x10 at cycle 0; mem_ready=1 with mem_rdata=0x00000013.
  - Required: mem_addr=0x10, mem_we=0 at cycle 1; i_ready=1 and i_rdata=0x13 at cycle 1; wait_i=1.
- Simultaneous requests:
  - Stimulus: i_req and d_req (load, addr 0x80) both asserted at cycle 0; mem_ready=1 every cycle.
  - Required: cycle 1 serves D (d_ready=1, mem_addr=0x80); cycle 2 serves I, with no idle bubble; wait_i=2, wait_d=1.
- Wait-state store:
  - Stimulus: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF; mem_ready held 0 for 3 cycles, then 1.
  - Required: mem_* stable for all 4 BUSY cycles; d_ready exactly one pulse; d_stall=1 for 4 cycles.
- Fairness:
  - Stimulus: both ports re-request immediately after each ready, for 8 transactions.
  - Required: grant order D, I, D, I, D, I, D, I; no port served twice consecutively while the other is pending.
- Reset mid-transaction:
  - Stimulus: assert reset during BUSY_D with mem_ready=0.
  - Required: mem_req=0 and the counters read 0 in the same cycle, without waiting for a clock edge; after release, an i_req is granted normally.
- Saturation:
  - Stimulus: CW=4; hold i_req with mem_ready=0 for 20 cycles.
  - Required: wait_i stops at 15.
